// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// Optional feature macro: PERF_BACKEDGE_EN (adds the backward-branch counter
// and a fifth snapshot word).
package perf_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] IDX_CYCLE    = 3'd0;
    localparam logic [2:0] IDX_STALL    = 3'd1;
    localparam logic [2:0] IDX_FLUSH    = 3'd2;
    localparam logic [2:0] IDX_INSTR    = 3'd3;
    localparam logic [2:0] IDX_BACKEDGE = 3'd4;

`ifdef PERF_BACKEDGE_EN
    localparam logic [2:0] LAST_IDX = IDX_BACKEDGE;
`else
    localparam logic [2:0] LAST_IDX = IDX_INSTR;
`endif

endpackage

// File: rtl/pipeline_perf_monitor_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    // Count up on inc, hold at the ceiling, zero on reset or clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Pipeline performance monitor: counts cycles, stalls, flushes and issued
// instructions while the core runs, halts on a cycle budget or stop pulse,
// then streams a counter snapshot over a valid/ready port.
// Optional feature macro: PERF_BACKEDGE_EN (backward-branch counter, word 4).
module pipeline_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             stop_i,
    input  logic             clear_i,
    output logic             halt_o,
    output logic             busy_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [2:0]       rd_idx_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [PC_W-1:0]  pc_last_o
);

    // state | meaning
    // IDLE  | waiting for start_i; the start edge is already counted
    // RUN   | counting while start_i is high, paused while low
    // DRAIN | streaming snapshot words 0..LAST_IDX over valid/ready
    // DONE  | counters frozen until clear_i

    localparam logic [CNT_W:0] BUDGET = (CNT_W+1)'(MAX_CYCLES);

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_idx;
    logic [PC_W-1:0]   r_pc_last;
    logic              r_pc_valid;
    logic              w_count, w_hit, w_clr, w_accept;
    logic [CNT_W-1:0]  w_cycle, w_stall, w_flush, w_instr;

    // A counted edge: the start edge out of IDLE, or a running edge without stop.
    assign w_count  = start_i && ((r_state == IDLE) || ((r_state == RUN) && !stop_i));
    assign w_hit    = (MAX_CYCLES != 0) && w_count &&
                      (({1'b0, w_cycle} + (CNT_W+1)'(1)) == BUDGET);
    assign w_clr    = (r_state == DONE) && clear_i;
    assign w_accept = (r_state == DRAIN) && rd_ready_i;

    perf_sat_counter #(.W(CNT_W)) u_cnt_cycle (.clk_i(clk_i), .rst_i(rst_i), .clr_i(w_clr),
        .inc_i(w_count), .cnt_o(w_cycle));
    perf_sat_counter #(.W(CNT_W)) u_cnt_stall (.clk_i(clk_i), .rst_i(rst_i), .clr_i(w_clr),
        .inc_i(w_count && stall_i), .cnt_o(w_stall));
    perf_sat_counter #(.W(CNT_W)) u_cnt_flush (.clk_i(clk_i), .rst_i(rst_i), .clr_i(w_clr),
        .inc_i(w_count && flush_i), .cnt_o(w_flush));
    perf_sat_counter #(.W(CNT_W)) u_cnt_instr (.clk_i(clk_i), .rst_i(rst_i), .clr_i(w_clr),
        .inc_i(w_count && !stall_i && !flush_i), .cnt_o(w_instr));

`ifdef PERF_BACKEDGE_EN
    logic [CNT_W-1:0] w_back;
    // r_pc_valid masks the first counted cycle, where r_pc_last is stale.
    perf_sat_counter #(.W(CNT_W)) u_cnt_back (.clk_i(clk_i), .rst_i(rst_i), .clr_i(w_clr),
        .inc_i(w_count && r_pc_valid && (pc_i < r_pc_last)), .cnt_o(w_back));
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        halt_o      = 1'b0;
        busy_o      = 1'b0;
        rd_valid_o  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_nxt = DRAIN;
                end else if (start_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (stop_i || w_hit) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                halt_o     = 1'b1;
                rd_valid_o = 1'b1;
                if (rd_ready_i && (r_idx == LAST_IDX)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                halt_o = 1'b1;
                if (clear_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Snapshot word index; parked at zero outside DRAIN.
    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != DRAIN)) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Last counted PC and the flag saying it belongs to the current run.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clr) begin
            r_pc_last  <= '0;
            r_pc_valid <= 1'b0;
        end else if (w_count) begin
            r_pc_last  <= pc_i;
            r_pc_valid <= 1'b1;
        end else if (r_state == IDLE) begin
            r_pc_valid <= 1'b0;
        end
    end

    // Snapshot word mux; zero whenever no word is on offer.
    always_comb begin
        rd_data_o = '0;
        if (r_state == DRAIN) begin
            case (r_idx)
                IDX_CYCLE:    rd_data_o = w_cycle;
                IDX_STALL:    rd_data_o = w_stall;
                IDX_FLUSH:    rd_data_o = w_flush;
                IDX_INSTR:    rd_data_o = w_instr;
`ifdef PERF_BACKEDGE_EN
                IDX_BACKEDGE: rd_data_o = w_back;
`endif
                default:      rd_data_o = '0;
            endcase
        end
    end

    assign rd_idx_o  = r_idx;
    assign pc_last_o = r_pc_last;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Self-checking bench for pipeline_perf_monitor against a behavioural model.
module tb_pipeline_perf_monitor;

    localparam int CNT_W = 32;
    localparam int PC_W  = 32;
    localparam int MAXC  = 30;
`ifdef PERF_BACKEDGE_EN
    localparam int NWORDS = 5;
`else
    localparam int NWORDS = 4;
`endif
    localparam longint SATV = (64'd1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            rst_i = 1'b0, start_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [PC_W-1:0] pc_i = '0;
    logic            stop_i = 1'b0, clear_i = 1'b0, rd_ready_i = 1'b0;
    logic            halt_o, busy_o, rd_valid_o;
    logic [2:0]      rd_idx_o;
    logic [CNT_W-1:0] rd_data_o;
    logic [PC_W-1:0] pc_last_o;

    pipeline_perf_monitor #(.CNT_W(CNT_W), .PC_W(PC_W), .MAX_CYCLES(MAXC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .flush_i(flush_i), .pc_i(pc_i), .stop_i(stop_i), .clear_i(clear_i),
        .halt_o(halt_o), .busy_o(busy_o), .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i), .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o),
        .pc_last_o(pc_last_o));

    // Narrow, unlimited-budget instance for saturation.
    logic        s_rst = 1'b0, s_start = 1'b0, s_stop = 1'b0, s_ready = 1'b0;
    logic        s_halt, s_busy, s_valid;
    logic [2:0]  s_idx;
    logic [3:0]  s_data;
    logic [31:0] s_pc_last;

    pipeline_perf_monitor #(.CNT_W(4), .PC_W(32), .MAX_CYCLES(0)) dut_s (
        .clk_i(clk_i), .rst_i(s_rst), .start_i(s_start), .stall_i(1'b0),
        .flush_i(1'b0), .pc_i(32'd0), .stop_i(s_stop), .clear_i(1'b0),
        .halt_o(s_halt), .busy_o(s_busy), .rd_valid_o(s_valid),
        .rd_ready_i(s_ready), .rd_idx_o(s_idx), .rd_data_o(s_data),
        .pc_last_o(s_pc_last));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 run, 2 drain, 3 done.
    int     m_phase = 0;
    bit     m_ok = 0;
    bit     m_prev = 0;
    int     m_idx = 0;
    longint m_w[5];
    longint m_pc = 0;
    longint q_data[$];
    int     q_idx[$];

    function automatic longint sat(input longint v);
        return (v > SATV) ? SATV : v;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 5; i++) m_w[i] = 0;
        m_pc = 0; m_prev = 0; m_idx = 0; m_phase = 0;
    endtask

    task automatic model_step();
        bit cnt;
        if (rst_i) begin
            model_zero();
            m_ok = 1;
            return;
        end
        case (m_phase)
            0, 1: begin
                cnt = start_i && !(m_phase == 1 && stop_i);
                if (m_phase == 1 && stop_i) m_phase = 2;
                else if (cnt) begin
                    m_w[0] = sat(m_w[0] + 1);
                    m_w[1] = sat(m_w[1] + longint'(stall_i));
                    m_w[2] = sat(m_w[2] + longint'(flush_i));
                    m_w[3] = sat(m_w[3] + longint'(!stall_i && !flush_i));
                    if (m_prev && longint'(pc_i) < m_pc) m_w[4] = sat(m_w[4] + 1);
                    m_pc = longint'(pc_i);
                    m_prev = 1;
                    m_phase = (MAXC != 0 && m_w[0] == MAXC) ? 2 : 1;
                end
            end
            2: if (rd_ready_i) begin
                if (m_idx == NWORDS - 1) begin m_phase = 3; m_idx = 0; end
                else m_idx++;
            end
            default: if (clear_i) model_zero();
        endcase
    endtask

    // Compare against the model every cycle, record accepted words, then advance.
    always @(negedge clk_i) begin
        if (m_ok) begin
            chk("halt",     halt_o,     longint'(m_phase >= 2));
            chk("busy",     busy_o,     longint'(m_phase == 1));
            chk("valid",    rd_valid_o, longint'(m_phase == 2));
            chk("idx",      rd_idx_o,   m_idx);
            chk("data",     rd_data_o,  (m_phase == 2) ? m_w[m_idx] : 0);
            chk("pc_last",  pc_last_o,  m_pc);
            if (rd_valid_o && rd_ready_i && !rst_i) begin
                q_data.push_back(longint'(rd_data_o));
                q_idx.push_back(int'(rd_idx_o));
            end
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(halt_o && !rd_valid_o) && n < 300) begin tick(); n++; end
        if (n >= 300) begin
            n_vec++; n_err++;
            $display("FAIL wait_done: timed out after %0d cycles", n);
        end
    endtask

    task automatic do_clear();
        clear_i = 1'b1; tick(); clear_i = 1'b0; tick();
    endtask

    task automatic chk_words(input string name, input longint e0, input longint e1,
                             input longint e2, input longint e3);
        longint e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({name, "_nwords"}, q_data.size(), NWORDS);
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            chk({name, "_word"}, q_data[i], e[i]);
            chk({name, "_order"}, q_idx[i], i);
        end
    endtask

    initial begin
        rst_i = 1'b1; tick(); tick();
        chk("reset_halt", halt_o, 0);
        chk("reset_valid", rd_valid_o, 0);
        chk("reset_pc", pc_last_o, 0);
        rst_i = 1'b0;

        // Budget halt; clear_i during RUN must be ignored.
        q_data.delete(); q_idx.delete();
        rd_ready_i = 1'b1; start_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            clear_i = (k < 10);
            tick();
        end
        clear_i = 1'b0;
        chk("budget_halt_after_30", halt_o, 1);
        wait_done();
        chk_words("budget", 30, 0, 0, 30);
        start_i = 1'b0; do_clear();

        // Stall/flush events.
        q_data.delete(); q_idx.delete();
        start_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            stall_i = (k >= 3 && k <= 5) || k == 20;
            flush_i = (k == 10 || k == 11) || k == 20;
            tick();
        end
        stall_i = 1'b0; flush_i = 1'b0;
        wait_done();
        chk_words("events", 30, 4, 3, 24);
        start_i = 1'b0; do_clear();

        // Pause then stop at cycle 12.
        q_data.delete(); q_idx.delete();
        start_i = 1'b1; repeat (6) tick();
        start_i = 1'b0; repeat (10) tick();
        chk("pause_busy", busy_o, 1);
        start_i = 1'b1; repeat (6) tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        wait_done();
        chk_words("stop", 12, 0, 0, 12);
        start_i = 1'b0; do_clear();

        // Backpressure.
        q_data.delete(); q_idx.delete();
        rd_ready_i = 1'b0; start_i = 1'b1;
        for (int n = 0; n < 100 && !rd_valid_o; n++) tick();
        start_i = 1'b0;
        repeat (5) tick();
        chk("bp_idx_held", rd_idx_o, 0);
        for (int n = 0; n < 100 && rd_valid_o; n++) begin
            rd_ready_i = ~rd_ready_i; tick();
        end
        chk_words("backpressure", 30, 0, 0, 30);
        rd_ready_i = 1'b1; do_clear();

        // Reset mid-DRAIN at index 2.
        start_i = 1'b1;
        for (int n = 0; n < 100 && !(rd_valid_o && rd_idx_o == 3'd2); n++) tick();
        chk("pre_reset_idx", rd_idx_o, 2);
        rst_i = 1'b1; rd_ready_i = 1'b0; start_i = 1'b0; tick(); rst_i = 1'b0;
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_idx", rd_idx_o, 0);
        chk("rst_halt", halt_o, 0);
        tick();

`ifdef PERF_BACKEDGE_EN
        begin
            logic [PC_W-1:0] pcs [8] = '{0, 4, 8, 12, 4, 8, 12, 4};
            q_data.delete(); q_idx.delete();
            rd_ready_i = 1'b1; start_i = 1'b1;
            for (int k = 0; k < 8; k++) begin pc_i = pcs[k]; tick(); end
            stop_i = 1'b1; tick(); stop_i = 1'b0; start_i = 1'b0;
            chk("be_pc_last", pc_last_o, 4);
            wait_done();
            chk_words("backedge", 8, 0, 0, 8);
            if (q_data.size() == 5) chk("be_count", q_data[4], 2);
            do_clear();
        end
`endif

        // Randomised traffic.
        for (int k = 0; k < 1500; k++) begin
            rst_i      = ($urandom % 300) == 0;
            start_i    = ($urandom % 6) != 0;
            stall_i    = ($urandom % 4) == 0;
            flush_i    = ($urandom % 5) == 0;
            pc_i       = PC_W'(($urandom % 32) * 4);
            stop_i     = ($urandom % 50) == 0;
            clear_i    = ($urandom % 8) == 0;
            rd_ready_i = ($urandom % 3) != 0;
            tick();
        end
        rst_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;

        // Saturation on the 4-bit unlimited instance.
        s_rst = 1'b1; tick(); tick(); s_rst = 1'b0;
        s_start = 1'b1; repeat (20) tick();
        chk("sat_busy", s_busy, 1);
        s_stop = 1'b1; tick(); s_stop = 1'b0; s_start = 1'b0;
        chk("sat_valid", s_valid, 1);
        chk("sat_idx", s_idx, 0);
        chk("sat_cycle_word", s_data, 15);
        s_ready = 1'b1; tick();
        chk("sat_stall_word", s_data, 0);
        repeat (NWORDS - 1) tick();
        chk("sat_done_valid", s_valid, 0);
        chk("sat_done_halt", s_halt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
